// File: rtl/nf_lookup_pkg.sv
// nf_lookup_pkg: FSM states, ethertype/opcode constants and tuser field offsets for the MAC lookup path
package nf_lookup_pkg;
  typedef enum logic [1:0] {HDR, REQ, WAIT, SEND} lookup_state_e;
  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] ARP_OP_REPLY = 16'h0002;
  localparam int TUSER_SRC_LSB = 16;
  localparam int TUSER_DST_LSB = 24;
endpackage

// File: rtl/mac_lookup_pkt_fifo.sv
// mac_lookup_pkt_fifo: first-word-fall-through beat buffer with full/empty flags
// ports: clk, rst (async, active-high); wr_en/din/full write side; rd_en/dout/empty read side (dout = head)
module mac_lookup_pkt_fifo #(
  parameter int W = 8,
  parameter int DEPTH_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         empty
);
  logic [W-1:0] mem_q [2**DEPTH_BITS];
  logic [DEPTH_BITS:0] wr_q, rd_q;
  assign empty = wr_q == rd_q;
  assign full = wr_q == {~rd_q[DEPTH_BITS], rd_q[DEPTH_BITS-1:0]};
  assign dout = mem_q[rd_q[DEPTH_BITS-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en && !full) wr_q <= wr_q + (DEPTH_BITS+1)'(1);
      if (rd_en && !empty) rd_q <= rd_q + (DEPTH_BITS+1)'(1);
    end
  always_ff @(posedge clk)
    if (wr_en && !full) mem_q[wr_q[DEPTH_BITS-1:0]] <= din;
endmodule

// File: rtl/mac_lookup_requester.sv
// mac_lookup_requester: buffers AXI-Stream packets, issues one MAC CAM lookup per packet, forwards with dst_ports in tuser
// ports: s_axis_* ingress, m_axis_* egress (tuser dst field replaced on first beat),
//        dst_mac/src_mac/src_port/opcode/lookup_req to the LUT, dst_ports/lookup_done/lut_hit/lut_miss back,
//        pkt/hit/miss/arp_reply counters (wrapping)
module mac_lookup_requester import nf_lookup_pkg::*; #(
  parameter int C_DATA_WIDTH = 256,
  parameter int C_USER_WIDTH = 128,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int FIFO_DEPTH_BITS = 5,
  parameter int LOOKUP_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [C_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_USER_WIDTH-1:0]      s_axis_tuser,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_USER_WIDTH-1:0]      m_axis_tuser,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [47:0]                  dst_mac,
  output logic [47:0]                  src_mac,
  output logic [NUM_OUTPUT_QUEUES-1:0] src_port,
  output logic [15:0]                  opcode,
  output logic                         lookup_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
  input  logic                         lookup_done,
  input  logic                         lut_hit,
  input  logic                         lut_miss,
  output logic [31:0]                  pkt_count,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count,
  output logic [31:0]                  arp_reply_count
);
  localparam int KW = C_DATA_WIDTH/8;
  localparam int FW = C_DATA_WIDTH + KW + C_USER_WIDTH + 2;
  localparam int TW = $clog2(LOOKUP_TIMEOUT) + 1;
  lookup_state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic first_q, first_d, sof_q;
  logic [47:0] dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
  logic [NUM_OUTPUT_QUEUES-1:0] src_port_q, src_port_d, dst_ports_q, dst_ports_d;
  logic [15:0] opcode_q, opcode_d;
  logic [31:0] pkt_q, pkt_d, hit_q, hit_d, miss_q, miss_d, arp_q, arp_d;
  logic full, empty, wr_en, rd_en;
  logic [FW-1:0] head;
  logic [C_DATA_WIDTH-1:0] h_data;
  logic [KW-1:0] h_keep;
  logic [C_USER_WIDTH-1:0] h_user, user_o;
  logic h_sof, h_last;
  logic [15:0] h_etype;
  assign wr_en = s_axis_tvalid && !full;
  assign s_axis_tready = !full && !reset;
  mac_lookup_pkt_fifo #(.W(FW), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
    .clk(clk),
    .rst(reset),
    .wr_en(wr_en),
    .din({s_axis_tlast, sof_q, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
    .full(full),
    .rd_en(rd_en),
    .dout(head),
    .empty(empty)
  );
  assign {h_last, h_sof, h_user, h_keep, h_data} = head;
  assign h_etype = h_data[C_DATA_WIDTH-97 -: 16];
  assign lookup_req = state_q == REQ;
  assign m_axis_tvalid = state_q == SEND && !empty;
  // egress fields are forced to zero when idle so the bus reads 0 during and after reset
  assign m_axis_tdata = m_axis_tvalid ? h_data : '0;
  assign m_axis_tkeep = m_axis_tvalid ? h_keep : '0;
  assign m_axis_tlast = m_axis_tvalid && h_last;
  assign m_axis_tuser = m_axis_tvalid ? user_o : '0;
  assign dst_mac = dst_mac_q;
  assign src_mac = src_mac_q;
  assign src_port = src_port_q;
  assign opcode = opcode_q;
  assign pkt_count = pkt_q;
  assign hit_count = hit_q;
  assign miss_count = miss_q;
  assign arp_reply_count = arp_q;
  always_comb begin
    user_o = h_user;
    if (first_q) user_o[TUSER_DST_LSB +: NUM_OUTPUT_QUEUES] = dst_ports_q;
  end
  always_comb begin
    state_d = state_q;
    tmo_d = tmo_q;
    first_d = first_q;
    dst_mac_d = dst_mac_q;
    src_mac_d = src_mac_q;
    src_port_d = src_port_q;
    opcode_d = opcode_q;
    dst_ports_d = dst_ports_q;
    pkt_d = pkt_q;
    hit_d = hit_q;
    miss_d = miss_q;
    arp_d = arp_q;
    rd_en = 1'b0;
    case (state_q)
      HDR: if (!empty) begin
        if (h_sof) begin
          dst_mac_d = h_data[C_DATA_WIDTH-1 -: 48];
          src_mac_d = h_data[C_DATA_WIDTH-49 -: 48];
          src_port_d = h_user[TUSER_SRC_LSB +: NUM_OUTPUT_QUEUES];
          opcode_d = h_etype == ETHERTYPE_ARP ? h_data[C_DATA_WIDTH-161 -: 16] : 16'h0;
          state_d = REQ;
        end else rd_en = 1'b1; // headerless continuation beat: drop it
      end
      REQ: begin
        tmo_d = '0;
        state_d = WAIT;
      end
      WAIT: if (lookup_done) begin
        dst_ports_d = dst_ports;
        hit_d = lut_hit ? hit_q + 32'd1 : hit_q;
        miss_d = lut_miss ? miss_q + 32'd1 : miss_q;
        arp_d = opcode_q == ARP_OP_REPLY ? arp_q + 32'd1 : arp_q;
        first_d = 1'b1;
        state_d = SEND;
      end else begin
        // WAIT lasts LOOKUP_TIMEOUT-1 cycles so successive request pulses are LOOKUP_TIMEOUT apart
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TW'(LOOKUP_TIMEOUT-2)) state_d = REQ;
      end
      SEND: if (m_axis_tvalid && m_axis_tready) begin
        rd_en = 1'b1;
        first_d = 1'b0;
        if (h_last) begin
          pkt_d = pkt_q + 32'd1;
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= HDR;
      tmo_q <= '0;
      first_q <= 1'b0;
      sof_q <= 1'b1;
      dst_mac_q <= '0;
      src_mac_q <= '0;
      src_port_q <= '0;
      opcode_q <= '0;
      dst_ports_q <= '0;
      pkt_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
      arp_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      first_q <= first_d;
      if (wr_en) sof_q <= s_axis_tlast;
      dst_mac_q <= dst_mac_d;
      src_mac_q <= src_mac_d;
      src_port_q <= src_port_d;
      opcode_q <= opcode_d;
      dst_ports_q <= dst_ports_d;
      pkt_q <= pkt_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      arp_q <= arp_d;
    end
endmodule

// File: tb/tb_mac_lookup_requester.sv
// tb_mac_lookup_requester: scoreboard bench with a LUT model for mac_lookup_requester
module tb_mac_lookup_requester;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [255:0] s_axis_tdata = '0, m_axis_tdata;
  logic [31:0] s_axis_tkeep = '0, m_axis_tkeep;
  logic [127:0] s_axis_tuser = '0, m_axis_tuser;
  logic s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
  logic m_axis_tvalid, m_axis_tready = 1, m_axis_tlast;
  logic [47:0] dst_mac, src_mac;
  logic [7:0] src_port, dst_ports = '0;
  logic [15:0] opcode;
  logic lookup_req, lookup_done = 0, lut_hit = 0, lut_miss = 0;
  logic [31:0] pkt_count, hit_count, miss_count, arp_reply_count;

  mac_lookup_requester dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .dst_mac(dst_mac), .src_mac(src_mac), .src_port(src_port), .opcode(opcode),
    .lookup_req(lookup_req), .dst_ports(dst_ports), .lookup_done(lookup_done),
    .lut_hit(lut_hit), .lut_miss(lut_miss),
    .pkt_count(pkt_count), .hit_count(hit_count), .miss_count(miss_count),
    .arp_reply_count(arp_reply_count)
  );

  typedef struct {logic [255:0] d; logic [31:0] k; logic [127:0] u; logic l;} beat_t;
  typedef struct {logic [47:0] dm; logic [47:0] sm; logic [7:0] sp; logic [15:0] op;} key_t;
  beat_t exp_q[$];
  key_t key_q[$];
  int req_cyc[$];
  int passed = 0, total = 0, beats_out = 0, req_cnt = 0, cyc = 0, lut_busy = 0, rdy_mode = 0;
  bit saw_full = 0, lut_is_hit = 1;
  logic [7:0] lut_ports = '0;
  logic [1:0] pend = '0;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? !m_axis_tready : 1'b0;
  end

  // egress monitor
  initial forever begin
    @(negedge clk);
    if (!reset && s_axis_tvalid && !s_axis_tready) saw_full = 1;
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      beats_out++;
      if (exp_q.size() == 0) chk("unexpected egress beat", exp_q.size(), 1);
      else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("m tdata", m_axis_tdata, e.d);
        chk("m tkeep", m_axis_tkeep, e.k);
        chk("m tuser", m_axis_tuser, e.u);
        chk("m tlast", m_axis_tlast, e.l);
      end
    end
  end

  // LUT model: ignores requests while busy, answers 2 cycles after an accepted request
  initial forever begin
    @(negedge clk);
    lookup_done = 0; lut_hit = 0; lut_miss = 0; dst_ports = '0;
    if (reset) pend = '0;
    else begin
      if (lut_busy > 0) lut_busy--;
      if (pend[1]) begin
        lookup_done = 1; lut_hit = lut_is_hit; lut_miss = !lut_is_hit; dst_ports = lut_ports;
        if (key_q.size() > 0) void'(key_q.pop_front());
      end
      if (lookup_req) begin
        req_cnt++;
        req_cyc.push_back(cyc);
        if (key_q.size() == 0) chk("stray lookup_req", key_q.size(), 1);
        else begin
          chk("req dst_mac", dst_mac, key_q[0].dm);
          chk("req src_mac", src_mac, key_q[0].sm);
          chk("req src_port", src_port, key_q[0].sp);
          chk("req opcode", opcode, key_q[0].op);
        end
      end
      pend = {pend[0], lookup_req && lut_busy == 0};
    end
  end

  task automatic send_pkt(input int n, input logic [7:0] id, input logic [47:0] dm, input logic [47:0] sm,
                          input logic [15:0] et, input logic [15:0] op, input logic [7:0] sp, input logic [7:0] dp);
    beat_t b, e;
    key_t k;
    int w;
    k.dm = dm; k.sm = sm; k.sp = sp; k.op = et == 16'h0806 ? op : 16'h0;
    key_q.push_back(k);
    for (int i = 0; i < n; i++) begin
      b.d = {8{id, 8'(i), 16'hC3A5}};
      if (i == 0) b.d[255:80] = {dm, sm, et, 48'h0001_0800_0604, op};
      b.k = i == n-1 ? 32'hFFFF_FFF0 : 32'hFFFF_FFFF;
      b.u = {id, 8'(i), 80'h0123_4567_89AB_CDEF_0F1E, 8'h5A, sp, 16'hBEEF};
      b.l = i == n-1;
      @(negedge clk);
      s_axis_tvalid = 1; s_axis_tdata = b.d; s_axis_tkeep = b.k; s_axis_tuser = b.u; s_axis_tlast = b.l;
      w = 0;
      while (!s_axis_tready && w < 2000) begin @(negedge clk); w++; end
      if (w == 2000) begin chk("ingress stall timeout", w, 0); break; end
      e = b;
      if (i == 0) e.u[31:24] = dp;
      exp_q.push_back(e);
    end
    @(negedge clk);
    s_axis_tvalid = 0; s_axis_tlast = 0;
  endtask

  task automatic wait_drain(input string nm);
    int w = 0;
    while ((exp_q.size() > 0 || key_q.size() > 0) && w < 3000) begin @(posedge clk); w++; end
    chk({nm, " drain"}, exp_q.size() + key_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int req0, b0, w;
    lut_busy = 20; lut_ports = 8'h02; lut_is_hit = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst m_tvalid", m_axis_tvalid, 0);
    chk("rst s_tready", s_axis_tready, 0);
    chk("rst lookup_req", lookup_req, 0);
    chk("rst dst_mac", dst_mac, 0);
    chk("rst pkt_count", pkt_count, 0);
    chk("rst hit_count", hit_count, 0);
    @(negedge clk);
    reset = 0;
    // 1: LUT initialising, requests retried every 16 cycles
    send_pkt(2, 8'h01, 48'h0000_0000_0A0A, 48'h0200_0000_0001, 16'h0800, 16'h0, 8'h01, 8'h02);
    wait_drain("t1");
    chk("t1 retried", req_cyc.size() >= 2, 1);
    for (int i = 1; i < req_cyc.size(); i++) chk("t1 req spacing", req_cyc[i] - req_cyc[i-1], 16);
    chk("t1 pkt_count", pkt_count, 1);
    chk("t1 hit_count", hit_count, 1);
    // 2: hit with 0x04
    lut_ports = 8'h04; lut_is_hit = 1;
    send_pkt(3, 8'h02, 48'h0011_2233_4455, 48'h0200_0000_0002, 16'h0800, 16'h0, 8'h01, 8'h04);
    wait_drain("t2");
    chk("t2 hit_count", hit_count, 2);
    // 3: miss with 0x54
    lut_ports = 8'h54; lut_is_hit = 0;
    send_pkt(2, 8'h03, 48'hDEAD_BEEF_0001, 48'h0200_0000_0003, 16'h0800, 16'h0, 8'h02, 8'h54);
    wait_drain("t3");
    chk("t3 miss_count", miss_count, 1);
    chk("t3 hit_count", hit_count, 2);
    // 4: ARP reply, then IPv4 carrying 0002 at the opcode position
    lut_ports = 8'h01; lut_is_hit = 1;
    send_pkt(2, 8'h04, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0004, 16'h0806, 16'h0002, 8'h08, 8'h01);
    wait_drain("t4a");
    chk("t4 arp_reply_count", arp_reply_count, 1);
    send_pkt(1, 8'h05, 48'h0011_2233_4455, 48'h0200_0000_0005, 16'h0800, 16'h0002, 8'h08, 8'h01);
    wait_drain("t4b");
    chk("t4 arp after ipv4", arp_reply_count, 1);
    chk("t4 pkt_count", pkt_count, 5);
    // 5: 40-beat packet overfilling the buffer, then 50% egress backpressure
    req0 = req_cnt; saw_full = 0; rdy_mode = 2;
    fork
      send_pkt(40, 8'h06, 48'h0011_2233_4455, 48'h0200_0000_0006, 16'h0800, 16'h0, 8'h01, 8'h01);
      begin
        w = 0;
        while (!saw_full && w < 500) begin @(posedge clk); w++; end
        rdy_mode = 1;
      end
    join
    wait_drain("t5");
    rdy_mode = 0;
    chk("t5 s_tready dropped", saw_full, 1);
    chk("t5 single req", req_cnt - req0, 1);
    chk("t5 pkt_count", pkt_count, 6);
    // 6: reset during egress of an 8-beat packet
    rdy_mode = 2;
    send_pkt(8, 8'h07, 48'h0011_2233_4455, 48'h0200_0000_0007, 16'h0800, 16'h0, 8'h01, 8'h01);
    b0 = beats_out; rdy_mode = 0; w = 0;
    while (beats_out < b0 + 3 && w < 500) begin @(posedge clk); w++; end
    chk("t6 egress started", beats_out >= b0 + 3, 1);
    @(posedge clk);
    #2 reset = 1;
    #1;
    exp_q.delete(); key_q.delete();
    chk("t6 m_tvalid", m_axis_tvalid, 0);
    chk("t6 m_tdata", m_axis_tdata, 0);
    chk("t6 s_tready", s_axis_tready, 0);
    chk("t6 lookup_req", lookup_req, 0);
    chk("t6 pkt_count", pkt_count, 0);
    chk("t6 dst_mac", dst_mac, 0);
    req0 = req_cnt;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (30) @(posedge clk);
    chk("t6 no stray req", req_cnt - req0, 0);
    lut_ports = 8'h10;
    send_pkt(3, 8'h08, 48'h0011_2233_4466, 48'h0200_0000_0008, 16'h0800, 16'h0, 8'h04, 8'h10);
    wait_drain("t6");
    chk("t6 post pkt_count", pkt_count, 1);
    chk("t6 post hit_count", hit_count, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
